// File: rtl/gf180mcu_fd_io__pwr_seq.sv
// GF180MCU IO ring power sequencer: orders DVDD then VDD switch-on,
// holds pad isolation until both rails settle, reverses on power-down.
module gf180mcu_fd_io__pwr_seq #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_dvdd_ok,
  input  logic       i_vdd_ok,
  output logic       o_dvdd_en,
  output logic       o_vdd_en,
  output logic       o_iso,
  output logic       o_ready,
  output logic       o_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_DV_UP   = 3'd1,
    S_CORE_UP = 3'd2,
    S_RELEASE = 3'd3,
    S_ON      = 3'd4,
    S_ISO_SET = 3'd5,
    S_CORE_DN = 3'd6,
    S_FLT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] r_tcnt;
  logic             r_dv_s1;
  logic             r_dv_s2;
  logic             r_vd_s1;
  logic             r_vd_s2;
  logic             r_dvdd_en;
  logic             r_vdd_en;
  logic             r_iso;
  logic             r_ready;
  logic             r_fault;
  logic             w_settle_ok;
  logic             w_settle_done;
  logic             w_tmo_done;
  logic             w_dvdd_en;
  logic             w_vdd_en;
  logic             w_iso;
  logic             w_ready;
  logic             w_fault;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dv_s1 <= 1'b0;
      r_dv_s2 <= 1'b0;
      r_vd_s1 <= 1'b0;
      r_vd_s2 <= 1'b0;
    end else begin
      r_dv_s1 <= i_dvdd_ok;
      r_dv_s2 <= r_dv_s1;
      r_vd_s1 <= i_vdd_ok;
      r_vd_s2 <= r_vd_s1;
    end
  end

  // Ramp states watch their rail; the fixed dwell states count freely.
  always_comb begin
    w_settle_ok = 1'b0;
    unique case (r_state)
      S_DV_UP:   w_settle_ok = r_dv_s2;
      S_CORE_UP: w_settle_ok = r_dv_s2 & r_vd_s2;
      S_RELEASE,
      S_ISO_SET,
      S_CORE_DN: w_settle_ok = 1'b1;
      default:   w_settle_ok = 1'b0;
    endcase
  end

  assign w_settle_done = w_settle_ok && (r_scnt == SETTLE_LAST);
  assign w_tmo_done    = (r_tcnt == TMO_LAST);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_OFF: begin
        if (i_en) w_nxt = S_DV_UP;
      end
      S_DV_UP: begin
        if (!i_en)              w_nxt = S_ISO_SET;
        else if (w_settle_done) w_nxt = S_CORE_UP;
        else if (w_tmo_done)    w_nxt = S_FLT;
      end
      S_CORE_UP: begin
        if (!i_en)              w_nxt = S_ISO_SET;
        else if (w_settle_done) w_nxt = S_RELEASE;
        else if (w_tmo_done)    w_nxt = S_FLT;
      end
      S_RELEASE: begin
        if (!i_en)              w_nxt = S_ISO_SET;
        else if (w_settle_done) w_nxt = S_ON;
      end
      S_ON: begin
        if (!r_dv_s2 || !r_vd_s2) w_nxt = S_FLT;
        else if (!i_en)           w_nxt = S_ISO_SET;
      end
      S_ISO_SET: begin
        if (w_settle_done) w_nxt = S_CORE_DN;
      end
      S_CORE_DN: begin
        if (w_settle_done) w_nxt = S_OFF;
      end
      S_FLT: begin
        if (!i_en) w_nxt = S_OFF;
      end
    endcase
  end

  // Decode from next state so outputs register alongside the state.
  always_comb begin
    w_dvdd_en = 1'b0;
    w_vdd_en  = 1'b0;
    w_iso     = 1'b1;
    w_ready   = 1'b0;
    w_fault   = 1'b0;
    unique case (w_nxt)
      S_OFF:     ;
      S_DV_UP:   w_dvdd_en = 1'b1;
      S_CORE_UP,
      S_RELEASE,
      S_ISO_SET: begin
        w_dvdd_en = 1'b1;
        w_vdd_en  = 1'b1;
      end
      S_ON: begin
        w_dvdd_en = 1'b1;
        w_vdd_en  = 1'b1;
        w_iso     = 1'b0;
        w_ready   = 1'b1;
      end
      S_CORE_DN: w_dvdd_en = 1'b1;
      S_FLT:     w_fault   = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_OFF;
      r_scnt    <= '0;
      r_tcnt    <= '0;
      r_dvdd_en <= 1'b0;
      r_vdd_en  <= 1'b0;
      r_iso     <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_dvdd_en <= w_dvdd_en;
      r_vdd_en  <= w_vdd_en;
      r_iso     <= w_iso;
      r_ready   <= w_ready;
      r_fault   <= w_fault;
      if (w_nxt != r_state) begin
        r_scnt <= '0;
        r_tcnt <= '0;
      end else begin
        if (!w_settle_ok)     r_scnt <= '0;
        else if (r_scnt != '1) r_scnt <= r_scnt + 1'b1;
        if (r_tcnt != '1)     r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign o_dvdd_en = r_dvdd_en;
  assign o_vdd_en  = r_vdd_en;
  assign o_iso     = r_iso;
  assign o_ready   = r_ready;
  assign o_fault   = r_fault;
  assign o_state   = r_state;

endmodule

// File: tb/tb_gf180mcu_fd_io__pwr_seq.sv
// Bench for the IO ring power sequencer: directed sequences plus
// randomized EN/OK traffic against a dwell-and-run-length model.
module tb_gf180mcu_fd_io__pwr_seq;

  localparam int S  = 4;
  localparam int TO = 20;

  localparam int M_OFF = 0, M_DV = 1, M_CORE = 2, M_REL = 3;
  localparam int M_ON = 4, M_ISO = 5, M_CDN = 6, M_FLT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dvdd_ok = 1'b0;
  logic       vdd_ok = 1'b0;
  logic       dvdd_en;
  logic       vdd_en;
  logic       iso;
  logic       ready;
  logic       fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  int m_st, m_dwell, m_run;
  bit m_d1, m_d2, m_v1, m_v2;

  gf180mcu_fd_io__pwr_seq #(
    .SETTLE_CYC(S), .TIMEOUT_CYC(TO), .CNT_W(11)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_dvdd_ok(dvdd_ok), .i_vdd_ok(vdd_ok),
    .o_dvdd_en(dvdd_en), .o_vdd_en(vdd_en), .o_iso(iso),
    .o_ready(ready), .o_fault(fault), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // {dvdd_en, vdd_en, iso, ready, fault} expected for each state
  function automatic int exp_out(input int st);
    case (st)
      M_OFF:  return 5'b00100;
      M_DV:   return 5'b10100;
      M_CORE: return 5'b11100;
      M_REL:  return 5'b11100;
      M_ON:   return 5'b11010;
      M_ISO:  return 5'b11100;
      M_CDN:  return 5'b10100;
      default: return 5'b00101;
    endcase
  endfunction

  task automatic m_reset();
    m_st = M_OFF; m_dwell = 0; m_run = 0;
    m_d1 = 0; m_d2 = 0; m_v1 = 0; m_v2 = 0;
  endtask

  task automatic m_step(input bit e, input bit dv, input bit vd);
    bit sdv, svd;
    int nx;
    sdv = m_d2; svd = m_v2;
    m_d2 = m_d1; m_d1 = dv;
    m_v2 = m_v1; m_v1 = vd;
    nx = m_st;
    m_dwell++;
    case (m_st)
      M_OFF: if (e) nx = M_DV;
      M_DV, M_CORE: begin
        if (m_st == M_DV) m_run = sdv ? m_run + 1 : 0;
        else m_run = (sdv && svd) ? m_run + 1 : 0;
        if (!e) nx = M_ISO;
        else if (m_run >= S) nx = m_st + 1;
        else if (m_dwell >= TO) nx = M_FLT;
      end
      M_REL: if (!e) nx = M_ISO; else if (m_dwell >= S) nx = M_ON;
      M_ON: if (!sdv || !svd) nx = M_FLT; else if (!e) nx = M_ISO;
      M_ISO: if (m_dwell >= S) nx = M_CDN;
      M_CDN: if (m_dwell >= S) nx = M_OFF;
      default: if (!e) nx = M_OFF;
    endcase
    if (nx != m_st) begin
      m_st = nx; m_dwell = 0; m_run = 0;
    end
  endtask

  task automatic cmp_all();
    chk("state", int'(state), m_st);
    chk("outs", int'({dvdd_en, vdd_en, iso, ready, fault}), exp_out(m_st));
    chk("inv_vdd_dvdd", int'(!vdd_en || dvdd_en), 1);
    chk("inv_iso_on", int'(iso || state == 3'd4), 1);
  endtask

  task automatic cyc(input bit e, input bit dv, input bit vd);
    @(negedge clk);
    en = e; dvdd_ok = dv; vdd_ok = vd;
    @(posedge clk);
    m_step(e, dv, vd);
    #1;
    cmp_all();
  endtask

  task automatic to_off();
    for (int i = 0; i < 12 && m_st != M_OFF; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("to_off", int'(state), 0);
  endtask

  bit ren, rdv, rvd;
  int stuck;

  initial begin
    m_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'({dvdd_en, vdd_en, iso, ready, fault}), 5'b00100);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Nominal up, OKs settled high first
    cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    cyc(1, 1, 1);
    chk("up_e0_dven", int'(dvdd_en), 1);
    chk("up_e0_vden", int'(vdd_en), 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 1, 1);
      if (k == 3)  chk("up_e3_st", int'(state), 1);
      if (k == 4)  chk("up_e4_vden", int'(vdd_en), 1);
      if (k == 8)  chk("up_e8_st", int'(state), 3);
      if (k == 11) chk("up_e11_iso", int'(iso), 1);
    end
    chk("up_on_st", int'(state), 4);
    chk("up_on_iso", int'(iso), 0);
    chk("up_on_rdy", int'(ready), 1);

    // Nominal down
    cyc(0, 1, 1);
    chk("dn_d0_iso", int'(iso), 1);
    chk("dn_d0_rdy", int'(ready), 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 1);
      if (k == 3) chk("dn_d3_vden", int'(vdd_en), 1);
      if (k == 4) chk("dn_d4_vden", int'(vdd_en), 0);
      if (k == 7) chk("dn_d7_dven", int'(dvdd_en), 1);
    end
    chk("dn_d8_dven", int'(dvdd_en), 0);
    chk("dn_d8_st", int'(state), 0);

    // Core timeout with VDD stuck low
    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(1, 1, 0);
    for (int k = 1; k <= 24; k++) begin
      cyc(1, 1, 0);
      if (k == 23) chk("tmo_e23_st", int'(state), 2);
    end
    chk("tmo_st", int'(state), 7);
    chk("tmo_fault", int'(fault), 1);
    chk("tmo_en", int'({dvdd_en, vdd_en}), 0);
    cyc(1, 1, 0);
    chk("tmo_hold", int'(state), 7);
    cyc(0, 1, 0);
    chk("tmo_clr_st", int'(state), 0);
    chk("tmo_clr_flt", int'(fault), 0);

    // DVDD glitch while in DV_UP
    cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 1); cyc(1, 1, 1); cyc(1, 1, 1);
    cyc(1, 0, 1);
    for (int k = 5; k <= 9; k++) cyc(1, 1, 1);
    chk("gl_e9_st", int'(state), 1);
    cyc(1, 1, 1);
    chk("gl_e10_st", int'(state), 2);

    // Abort during CORE_UP
    cyc(1, 1, 1);
    cyc(0, 1, 1);
    chk("ab_iso_st", int'(state), 5);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 1);
      if (k == 3) chk("ab_k3_st", int'(state), 5);
      if (k == 4) chk("ab_k4_st", int'(state), 6);
      if (k == 7) chk("ab_k7_st", int'(state), 6);
    end
    chk("ab_off_st", int'(state), 0);

    // Brown-out in ON
    for (int k = 0; k <= 12; k++) cyc(1, 1, 1);
    chk("bo_on", int'(state), 4);
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    chk("bo_fault", int'(fault), 1);
    chk("bo_iso", int'(iso), 1);
    chk("bo_rdy", int'(ready), 0);
    to_off();

    // Async reset pulse mid-RELEASE
    for (int k = 0; k <= 9; k++) cyc(1, 1, 1);
    chk("ar_rel", int'(state), 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_outs", int'({dvdd_en, vdd_en, iso, ready, fault}), 5'b00100);
    rst = 1'b0;
    m_reset();
    cyc(0, 1, 1);

    // Randomized traffic
    ren = 0; stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ren = ~ren;
      if (stuck == 0 && $urandom_range(0, 199) == 0)
        stuck = $urandom_range(5, 30);
      rdv = ($urandom_range(0, 79) != 0);
      if (stuck > 0) begin
        rvd = 1'b0;
        stuck--;
      end else begin
        rvd = ($urandom_range(0, 59) != 0);
      end
      cyc(ren, rdv, rvd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
